exc_sequencer: RTL and testbench
================================

// Module: exc_sequencer
// PURPOSE
// - Trap/exception sequencer between the ID stage and CP0. Decodes syscall, break, teq and eret
//   from the instruction in ID.
// - Drives the CP0 exception request (exception/eret/cause/pc) as a single-cycle pulse.
// - Stalls fetch while the request is in flight, then redirects the PC to the CP0 exc_addr.
// PARAMETERS
// - RESET_PC     32'h0040_0000  value of redirect_pc after reset
// - SYNC_STAGES  2              irq synchroniser depth (used only with EXC_IRQ_EN; legal values >=2)
// PORTS
// - clk            in   1   clock, rising edge
// - rst            in   1   reset, asynchronous, active-high
// - instr_valid    in   1   instr/pc/rs_val/rt_val are valid this cycle
// - instr          in   32  instruction word in ID
// - pc             in   32  address of instr
// - rs_val         in   32  GPR[rs] operand (teq compare)
// - rt_val         in   32  GPR[rt] operand (teq compare)
// - status         in   32  CP0 status register (reg 12)
// - exc_addr       in   32  CP0 exception/return target
// - irq            in   1   async external interrupt (ignored unless EXC_IRQ_EN)
// - cp0_exception  out  1   exception request pulse to CP0
// - cp0_eret       out  1   eret qualifier, valid with cp0_exception
// - cp0_cause      out  5   01000 syscall, 01001 break, 01101 teq, 00000 eret/interrupt
// - cp0_pc         out  32  EPC candidate (pc of trapping instruction)
// - stall          out  1   freeze PC/IF/ID
// - redirect       out  1   one-cycle PC load strobe
// - redirect_pc    out  32  PC load value
// - busy           out  1   FSM not IDLE
// BEHAVIOUR
// - Decode, combinational, qualified by instr_valid:
//   - Opcode 000000: funct 001100 = syscall; funct 001101 = break; funct 110100 = teq,
//     a hit only when rs_val == rt_val (full 32-bit compare).
//   - instr == 32'h4200_0018 = eret.
//   - Encodings are mutually exclusive. hit = any of the four.
// - FSM states: IDLE -> ISSUE -> WAIT -> REDIR -> IDLE. Every transition takes exactly one clock.
//   - IDLE: on hit, latch pc and cause (eret: cause 00000, eret flag 1) into holding regs, go to ISSUE.
//     No hit: stay in IDLE.
//   - ISSUE: cp0_exception=1 and cp0_eret=flag for exactly this cycle. cp0_cause and cp0_pc
//     come from the holding regs. CP0 updates exc_addr on the closing edge.
//   - WAIT: capture exc_addr into redirect_pc at the closing edge.
//   - REDIR: redirect=1 for this cycle only, with redirect_pc stable.
// - stall = (state!=IDLE) | (state==IDLE & hit). This is the only combinational path to an output.
// - busy = state!=IDLE.
// - Latency:
//   - Hit in cycle 0 -> exception pulse in cycle 1 -> redirect in cycle 3.
//   - First new instruction accepted in cycle 4.
// - instr_valid and the decode are ignored outside IDLE. No queuing; a trap instruction held
//   in ID is re-decoded only after the redirect.
// - Masked traps (status bit clear) are still issued. CP0 returns pc+4 and the sequencer
//   redirects there unchanged.
// - cp0_cause and cp0_pc are held stable from ISSUE until the next latch. They read 0 after reset.
// - Reset (any state, including mid-ISSUE/WAIT) has immediate effect:
//   - state=IDLE.
//   - cp0_exception, cp0_eret, redirect, stall, busy = 0.
//   - cp0_cause = 0, cp0_pc = 0, redirect_pc = RESET_PC.
//   - irq pending cleared.
// CONFIGURATION
// - EXC_IRQ_EN defined:
//   - irq passes through a SYNC_STAGES flop synchroniser. A rising edge sets irq_pending.
//   - In IDLE with instr_valid & !hit & irq_pending & status[0]: latch cause 00000, eret 0,
//     cp0_pc=pc, then run the normal sequence.
//   - irq_pending clears in ISSUE.
//   - A trap hit has priority; the interrupt stays pending.
//   - stall also asserts in IDLE when the interrupt is taken.
// - EXC_IRQ_EN undefined: irq port is present but unused, and no synchroniser or pending logic
//   is built. Behaviour is identical to the macro-defined build with irq held 0.
// TESTING
// - Syscall 0x0000000C at pc=0x0040_0010, status=0x0F:
//   - cycle 1: cp0_exception=1, cause=01000, cp0_pc=0x0040_0010.
//   - exc_addr=0x0040_0004 -> cycle 3: redirect=1, redirect_pc=0x0040_0004.
//   - stall high cycles 0-3.
// - Teq 0x0109_0034, rs_val=rt_val=5 -> cause=01101 pulse.
//   - Same instr with rt_val=6 -> no stall, no pulse, busy=0 throughout.
// - Eret 0x4200_0018, exc_addr=0x0040_0020 -> cp0_eret=1, cause=00000; redirect_pc=0x0040_0020.
// - Break at cycle 0, then syscall held valid cycles 1-3 -> exactly one pulse (01001) in cycle 1.
//   The held syscall is decoded again in cycle 4 -> second pulse (01000) in cycle 5.
// - Reset asserted in WAIT -> same cycle: redirect=0, stall=0, busy=0, redirect_pc=0x0040_0000.
//   No redirect afterwards.
// - [EXC_IRQ_EN] irq rises, status[0]=1, nop valid at pc=0x0040_0100:
//   - pulse with cause=00000, cp0_pc=0x0040_0100 within SYNC_STAGES+2 cycles.
//   - With status[0]=0: no pulse until status[0] is set.

Source files
------------

// File: rtl/exc_sequencer.sv
// Trap/exception sequencer between ID and CP0: decodes syscall/break/teq/eret,
// pulses the CP0 request, stalls fetch, then redirects. Optional macro: EXC_IRQ_EN.
module exc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] status,
    input  logic [31:0] exc_addr,
    input  logic        irq,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic [31:0] cp0_pc,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REDIR
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        eret_q;
    logic        latch;
    logic        hit;
    logic        is_sys;
    logic        is_brk;
    logic        is_teq;
    logic        is_eret;
    logic [4:0]  dec_cause;
    logic        irq_take;

    logic        special;
    assign special = instr[31:26] == 6'b000000;
    assign is_sys  = instr_valid & special & (instr[5:0] == 6'b001100);
    assign is_brk  = instr_valid & special & (instr[5:0] == 6'b001101);
    assign is_teq  = instr_valid & special & (instr[5:0] == 6'b110100)
                   & (rs_val == rt_val);
    assign is_eret = instr_valid & (instr == 32'h4200_0018);
    assign hit     = is_sys | is_brk | is_teq | is_eret;

    // Cause code for a decoded trap; eret reports 00000.
    always_comb begin
        dec_cause = 5'b00000;
        unique case (1'b1)
            is_sys:  dec_cause = 5'b01000;
            is_brk:  dec_cause = 5'b01001;
            is_teq:  dec_cause = 5'b01101;
            default: dec_cause = 5'b00000;
        endcase
    end

`ifdef EXC_IRQ_EN
    logic [SYNC_STAGES-1:0] irq_sync;
    logic                   irq_prev;
    logic                   irq_pending;
    logic                   irq_q;
    logic [30:0]            unused_status;
    assign unused_status = status[31:1];

    assign irq_take = (state_q == IDLE) & instr_valid & ~hit
                    & irq_pending & status[0];

    // Synchronise irq, detect its rising edge and hold it pending until issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync    <= '0;
            irq_prev    <= 1'b0;
            irq_pending <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq};
            irq_prev <= irq_sync[SYNC_STAGES-1];
            if (latch)
                irq_q <= irq_take;
            if (irq_sync[SYNC_STAGES-1] & ~irq_prev)
                irq_pending <= 1'b1;
            else if ((state_q == ISSUE) & irq_q)
                irq_pending <= 1'b0;
        end
    end
`else
    logic [32:0] unused_irq;
    assign unused_irq = {irq, status};
    assign irq_take   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: one clock per step once a trap or interrupt is taken.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit | irq_take) begin
                    latch   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Holding registers for the request and the redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp0_cause   <= 5'b00000;
            cp0_pc      <= 32'h0;
            eret_q      <= 1'b0;
            redirect_pc <= RESET_PC;
        end else begin
            if (latch) begin
                cp0_cause <= hit ? dec_cause : 5'b00000;
                cp0_pc    <= pc;
                eret_q    <= is_eret;
            end
            if (state_q == WAIT)
                redirect_pc <= exc_addr;
        end
    end

    assign cp0_exception = state_q == ISSUE;
    assign cp0_eret      = (state_q == ISSUE) & eret_q;
    assign redirect      = state_q == REDIR;
    assign busy          = state_q != IDLE;
    assign stall         = busy | hit | irq_take;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: directed traps, expected
// CP0 requests and redirects are queued and checked by a monitor.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] status;
    logic [31:0] exc_addr;
    logic        irq;
    logic        cp0_exception;
    logic        cp0_eret;
    logic [4:0]  cp0_cause;
    logic [31:0] cp0_pc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    typedef struct {
        logic [4:0]  cause;
        logic [31:0] pc;
        logic        eret;
    } exp_t;

    exp_t        exc_q[$];
    logic [31:0] red_q[$];
    int          checks = 0;
    int          failures = 0;

    exc_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .pc(pc), .rs_val(rs_val), .rt_val(rt_val), .status(status),
        .exc_addr(exc_addr), .irq(irq), .cp0_exception(cp0_exception),
        .cp0_eret(cp0_eret), .cp0_cause(cp0_cause), .cp0_pc(cp0_pc),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Monitor: every request or redirect must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (cp0_exception) begin
                if (exc_q.size() == 0) begin
                    chk("unexpected_exc", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = exc_q.pop_front();
                    chk("exc_cause", {27'h0, cp0_cause}, {27'h0, e.cause});
                    chk("exc_pc", cp0_pc, e.pc);
                    chk("exc_eret", {31'h0, cp0_eret}, {31'h0, e.eret});
                end
            end else begin
                chk("eret_no_exc", {31'h0, cp0_eret}, 32'h0);
            end
            if (redirect) begin
                if (red_q.size() == 0)
                    chk("unexpected_redir", 32'h1, 32'h0);
                else
                    chk("redir_pc", redirect_pc, red_q.pop_front());
            end
        end
    end

    // Full trap sequence from cycle 0 (decode) to cycle 4 (idle again).
    task automatic run_trap(input logic [31:0] ins, input logic [31:0] ipc,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] tgt, input logic [4:0] cause,
                            input logic er);
        exp_t e;
        e.cause = cause;
        e.pc = ipc;
        e.eret = er;
        exc_q.push_back(e);
        red_q.push_back(tgt);
        instr = ins;
        pc = ipc;
        rs_val = a;
        rt_val = b;
        exc_addr = tgt;
        instr_valid = 1'b1;
        half();
        chk("stall_c0", {31'h0, stall}, 32'h1);
        chk("busy_c0", {31'h0, busy}, 32'h0);
        tick();
        instr_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            half();
            chk("stall_busy_c123", {30'h0, stall, busy}, 32'h3);
            tick();
        end
        half();
        chk("idle_c4", {30'h0, stall, busy}, 32'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'h0;
        pc = 32'h0;
        rs_val = 32'h0;
        rt_val = 32'h0;
        status = 32'h0000_000F;
        exc_addr = 32'h0;
        irq = 1'b0;
        #12;
        chk("rst_cause", {27'h0, cp0_cause}, 32'h0);
        chk("rst_pc", cp0_pc, 32'h0);
        chk("rst_rpc", redirect_pc, 32'h0040_0000);
        chk("rst_flags", {cp0_exception, cp0_eret, redirect, stall, busy},
            32'h0);
        tick();
        rst = 1'b0;
        tick();

        run_trap(32'h0000_000C, 32'h0040_0010, 0, 0, 32'h0040_0004,
                 5'b01000, 1'b0);
        run_trap(32'h0109_0034, 32'h0040_0030, 5, 5, 32'h0040_0034,
                 5'b01101, 1'b0);

        instr = 32'h0109_0034;
        rs_val = 5;
        rt_val = 6;
        instr_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            half();
            chk("teq_miss", {30'h0, stall, busy}, 32'h0);
            tick();
        end
        instr_valid = 1'b0;

        run_trap(32'h4200_0018, 32'h0040_0050, 0, 0, 32'h0040_0020,
                 5'b00000, 1'b1);
        status = 32'h0;
        run_trap(32'h0000_000C, 32'h0040_0060, 0, 0, 32'h0040_0064,
                 5'b01000, 1'b0);
        status = 32'h0000_000F;

        begin
            exp_t e;
            e.cause = 5'b01001; e.pc = 32'h0040_0070; e.eret = 1'b0;
            exc_q.push_back(e);
            red_q.push_back(32'h0040_0074);
            e.cause = 5'b01000; e.pc = 32'h0040_0078; e.eret = 1'b0;
            exc_q.push_back(e);
            red_q.push_back(32'h0040_007C);
        end
        instr = 32'h0000_000D;
        pc = 32'h0040_0070;
        exc_addr = 32'h0040_0074;
        instr_valid = 1'b1;
        tick();
        instr = 32'h0000_000C;
        pc = 32'h0040_0078;
        for (int c = 1; c < 4; c++) begin
            half();
            chk("held_busy", {31'h0, busy}, 32'h1);
            tick();
        end
        exc_addr = 32'h0040_007C;
        half();
        chk("held_redecode", {30'h0, stall, busy}, 32'h2);
        tick();
        instr_valid = 1'b0;
        repeat (4) tick();

        begin
            exp_t e;
            e.cause = 5'b01000; e.pc = 32'h0040_0090; e.eret = 1'b0;
            exc_q.push_back(e);
        end
        instr = 32'h0000_000C;
        pc = 32'h0040_0090;
        exc_addr = 32'h0040_0094;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_wait_flags", {29'h0, redirect, stall, busy}, 32'h0);
        chk("rst_wait_rpc", redirect_pc, 32'h0040_0000);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            half();
            chk("post_rst_idle", {30'h0, redirect, busy}, 32'h0);
            tick();
        end

`ifdef EXC_IRQ_EN
        begin
            exp_t e;
            int   n;
            e.cause = 5'b00000; e.pc = 32'h0040_0100; e.eret = 1'b0;
            exc_q.push_back(e);
            red_q.push_back(32'h0040_0104);
            instr = 32'h0;
            pc = 32'h0040_0100;
            exc_addr = 32'h0040_0104;
            instr_valid = 1'b1;
            irq = 1'b1;
            n = 0;
            while (!cp0_exception && n < 8) begin
                tick();
                n++;
            end
            chk("irq_latency_ok", {31'h0, n <= 5}, 32'h1);
            instr_valid = 1'b0;
            irq = 1'b0;
            repeat (4) tick();
        end
`endif

        repeat (2) tick();
        chk("exc_q_drained", exc_q.size(), 0);
        chk("red_q_drained", red_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
